// File: rtl/store_tile_serializer.sv
// store_tile_serializer
//
// Byte engine at the end of the STORE path. After start it pulls source-buffer tiles one at a
// time from the buffer controller and turns each tile into single-byte DRAM writes over a
// req/ready port. It stops after exactly `length` elements. When the last byte has been
// accepted it pulses done.
//
// Optional feature: define STORE_SER_TIMEOUT_EN to abort a write that waits on mem_ready for
// TIMEOUT_CYCLES cycles. The abort drops mem_req, pulses error and returns to idle without a
// done pulse. With the macro undefined, error is tied low and waits are unbounded.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             begin an operation (only honoured when idle)
//   dram_addr         DRAM base byte address, latched on start
//   length            element count 0..1023, latched on start
//   buf_id            source buffer id, latched on start
//   buf_read_en/id    one-cycle tile read request to the buffer controller
//   buf_read_data     returned tile, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   buf_read_done     single-cycle strobe marking buf_read_data valid
//   mem_req/we        memory write request; we always mirrors req
//   mem_addr/wdata    write byte address and data
//   mem_ready         memory accepts the current beat
//   done              one-cycle completion pulse
//   error             one-cycle timeout abort pulse

module store_tile_serializer #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TILE_WIDTH = 256
`ifdef STORE_SER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [9:0]            length,
    input  logic [4:0]            buf_id,
    output logic                  buf_read_en,
    output logic [4:0]            buf_read_id,
    input  logic [TILE_WIDTH-1:0] buf_read_data,
    input  logic                  buf_read_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W      = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_ELEMS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrite,
        StFinish
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [9:0]            len_q, len_d;
    logic [9:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4:0]            rd_id_q, rd_id_d;
    logic                  rd_en_q, rd_en_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] tile_q [TILE_ELEMS];
    logic                  tile_load;
    logic [9:0]            cnt_inc;
    logic [IDX_W-1:0]      idx_inc;

`ifdef STORE_SER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    assign cnt_inc = cnt_q + 10'd1;
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rd_id_d   = rd_id_q;
        rd_en_d   = 1'b0;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        tile_load = 1'b0;
`ifdef STORE_SER_TIMEOUT_EN
        tmo_d     = '0;
        err_d     = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = dram_addr;
                    len_d   = length;
                    rd_id_d = buf_id;
                    cnt_d   = '0;
                    idx_d   = '0;
                    if (length == 10'd0) begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = StRdReq;
                    end
                end
            end

            // buf_read_en is already high this cycle; it was registered on entry.
            StRdReq: state_d = StRdWait;

            StRdWait: begin
                if (buf_read_done) begin
                    tile_load = 1'b1;
                    idx_d     = '0;
                    req_d     = 1'b1;
                    addr_d    = base_q + ADDR_WIDTH'(cnt_q);
                    wdata_d   = buf_read_data[DATA_WIDTH-1:0];
                    state_d   = StWrite;
                end
            end

            // mem_req is always high in this state, so mem_ready alone marks a handshake.
            StWrite: begin
                if (mem_ready) begin
                    cnt_d = cnt_inc;
                    idx_d = idx_inc;
                    if (cnt_inc == len_q) begin
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else if (idx_q == LAST_IDX) begin
                        req_d   = 1'b0;
                        rd_en_d = 1'b1;
                        state_d = StRdReq;
                    end else begin
                        addr_d  = base_q + ADDR_WIDTH'(cnt_inc);
                        wdata_d = tile_q[idx_inc];
                    end
                end
`ifdef STORE_SER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end

            StFinish: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            rd_id_q <= '0;
            rd_en_q <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rd_id_q <= rd_id_d;
            rd_en_q <= rd_en_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Tile storage is data-only and always written before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (tile_load) begin
            for (int i = 0; i < TILE_ELEMS; i++) begin
                tile_q[i] <= buf_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef STORE_SER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign buf_read_en = rd_en_q;
    assign buf_read_id = rd_id_q;
    assign mem_req     = req_q;
    assign mem_we      = req_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign done        = done_q;

endmodule

// File: tb/tb_store_tile_serializer.sv
// Bench for store_tile_serializer. The stimulus process issues operations and pushes the
// expected byte writes into a queue. The expectations come from a flat source-byte array.
// A separate monitor pops and compares on every memory handshake. It also checks done
// timing, the read ids and the stability of outputs while the memory stalls.

module tb_store_tile_serializer;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int TW = 256;
    localparam int TE = TW / DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] dram_addr;
    logic [9:0]    length;
    logic [4:0]    buf_id;
    logic          buf_read_en;
    logic [4:0]    buf_read_id;
    logic [TW-1:0] buf_read_data;
    logic          buf_read_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          done;
    logic          error;

    store_tile_serializer #(
`ifdef STORE_SER_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TILE_WIDTH(TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dram_addr    (dram_addr),
        .length       (length),
        .buf_id       (buf_id),
        .buf_read_en  (buf_read_en),
        .buf_read_id  (buf_read_id),
        .buf_read_data(buf_read_data),
        .buf_read_done(buf_read_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] src [0:1055];

    int checks;
    int passes;
    int hs_in_op, reads_seen, done_seen, err_seen, stall_obs, req_cycles;
    int tile_ptr, stall_left, ready_mode, rsp_delay;
    bit done_due, err_ok;
    logic [4:0] cur_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Buffer controller: returns the next sequential tile some cycles after each request.
    initial begin
        buf_read_done = 1'b0;
        buf_read_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && buf_read_en) begin
                rsp_delay = $urandom_range(0, 3);
                @(posedge clk);
                repeat (rsp_delay) @(posedge clk);
                #1;
                for (int j = 0; j < TE; j++) buf_read_data[j*DW +: DW] = src[tile_ptr*TE + j];
                buf_read_done = 1'b1;
                tile_ptr++;
                @(posedge clk);
                #1;
                buf_read_done = 1'b0;
                buf_read_data = TW'({$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom});
            end
        end
    end

    // Memory ready driver.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: mem_ready = 1'b1;
                1: mem_ready = ($urandom_range(0, 9) < 7);
                2: mem_ready = 1'b0;
                3: begin
                    if (hs_in_op == 2 && stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
                default: mem_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    bit            prev_stall, due_next;
    wr_t           e;

    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_due   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (buf_read_en) begin
                    reads_seen++;
                    chk("rd_id", 32'(buf_read_id), 32'(cur_id));
                end
                if (done || done_due) chk("done_timing", 32'(done), 32'(done_due));
                if (done) done_seen++;
                if (error) begin
                    chk("unexpected_error", 32'(error), 32'(err_ok));
                    err_seen++;
                end
                if (mem_req || mem_we) chk("we_eq_req", 32'(mem_we), 32'(mem_req));
                if (prev_stall && mem_req) begin
                    chk("stall_addr_stable", 32'(mem_addr), 32'(prev_addr));
                    chk("stall_data_stable", 32'(mem_wdata), 32'(prev_data));
                end
                if (mem_req) req_cycles++;
                due_next = 1'b0;
                if (mem_req && mem_ready) begin
                    hs_in_op++;
                    if (wq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                        chk("wr_data", 32'(mem_wdata), 32'(e.data));
                        due_next = e.last;
                    end
                end
                prev_stall = mem_req && !mem_ready;
                if (prev_stall) stall_obs++;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
                done_due  = due_next;
            end
        end
    end

    // Issues an operation; expected writes follow directly from the source byte stream.
    task automatic start_op(input logic [AW-1:0] base, input int len, input logic [4:0] id,
                            input bit pattern);
        for (int i = 0; i < 1056; i++) src[i] = pattern ? 8'(i + 1) : 8'($urandom);
        for (int i = 0; i < len; i++) begin
            wq.push_back('{addr: base + AW'(i), data: src[i], last: (i == len - 1)});
        end
        tile_ptr   = 0;
        hs_in_op   = 0;
        reads_seen = 0;
        stall_obs  = 0;
        req_cycles = 0;
        cur_id     = id;
        dram_addr  = base;
        length     = 10'(len);
        buf_id     = id;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dram_addr = AW'($urandom);
        length    = 10'($urandom);
        buf_id    = 5'($urandom);
        if (len == 0) begin
            done_due = 1'b1;
        end else begin
            @(negedge clk);
            chk("first_rd_en", 32'(buf_read_en), 32'd1);
        end
    endtask

    task automatic wait_done(input int len);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_count", 32'(done_seen - d0), 32'd1);
        chk("tiles_read", 32'(reads_seen), 32'((len + TE - 1) / TE));
        chk("queue_drained", 32'(wq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n, d0, e0, len;

    initial begin
        checks = 0; passes = 0;
        hs_in_op = 0; reads_seen = 0; done_seen = 0; err_seen = 0;
        stall_obs = 0; req_cycles = 0; tile_ptr = 0; stall_left = 0;
        ready_mode = 0; done_due = 1'b0; err_ok = 1'b0; cur_id = '0;
        start = 1'b0; dram_addr = '0; length = '0; buf_id = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_rd_en", 32'(buf_read_en), 32'd0);
        chk("rst_rd_id", 32'(buf_read_id), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Short single tile, back-to-back.
        start_op(24'h000100, 5, 5'd3, 1'b1);
        wait_done(5);
        chk("len5_req_cycles", 32'(req_cycles), 32'd5);

        // Three tiles with a partial last one; no bubbles with ready held high.
        start_op(AW'($urandom), 70, 5'd17, 1'b0);
        wait_done(70);
        chk("len70_req_cycles", 32'(req_cycles), 32'd70);

        // Zero length: done only, nothing else.
        start_op(24'h123456, 0, 5'd9, 1'b0);
        wait_done(0);
        chk("len0_req_cycles", 32'(req_cycles), 32'd0);

        // Seven-cycle stall on the third byte.
        ready_mode = 3;
        stall_left = 7;
        start_op(24'h000800, 10, 5'd1, 1'b0);
        wait_done(10);
        chk("stall_cycles", 32'(stall_obs), 32'd7);
        chk("stall_handshakes", 32'(hs_in_op), 32'd10);
        ready_mode = 0;

        // Address wrap at the top of the address space.
        start_op(24'hFFFFFE, 4, 5'd30, 1'b0);
        wait_done(4);

        // Random lengths with random ready; stray starts mid-operation must be ignored.
        ready_mode = 1;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(0, 150);
            start_op(AW'($urandom), len, 5'($urandom), 1'b0);
            if (len >= 40) begin
                @(posedge clk);
                #1;
                start     = 1'b1;
                dram_addr = AW'($urandom);
                length    = 10'($urandom);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            wait_done(len);
        end
        start_op(AW'($urandom), 1023, 5'd31, 1'b0);
        wait_done(1023);
        ready_mode = 0;

        // Reset while byte 10 of a 32-byte tile is being presented.
        start_op(24'h004000, 32, 5'd7, 1'b0);
        n = 0;
        while (hs_in_op < 9 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_wdata", 32'(mem_wdata), 32'd0);
        chk("midrst_rd_en", 32'(buf_read_en), 32'd0);
        chk("midrst_rd_id", 32'(buf_read_id), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        wq.delete();
        d0 = done_seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_seen), 32'(d0));
        start_op(24'h000200, 3, 5'd12, 1'b0);
        wait_done(3);

`ifdef STORE_SER_TIMEOUT_EN
        // mem_ready stuck low: error after 16 stalled cycles, no done, back to idle.
        ready_mode = 2;
        err_ok     = 1'b1;
        e0         = err_seen;
        d0         = done_seen;
        start_op(24'h000300, 3, 5'd5, 1'b0);
        n = 0;
        while (err_seen == e0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_error_pulses", 32'(err_seen - e0), 32'd1);
        chk("timeout_stall_cycles", 32'(stall_obs), 32'd16);
        chk("timeout_no_done", 32'(done_seen), 32'(d0));
        chk("timeout_req_low", 32'(mem_req), 32'd0);
        wq.delete();
        err_ok     = 1'b0;
        ready_mode = 0;
        start_op(24'h000400, 6, 5'd6, 1'b0);
        wait_done(6);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/store_tile_serializer.md
Name: store_tile_serializer

Overview:
Downstream byte engine of the STORE execution path. On start it fetches source-buffer tiles one at a time from the buffer controller. It then serializes each tile into single-byte DRAM writes over the req/ready memory port. It stops after exactly `length` elements and pulses done when the last byte has been accepted.

Parameters:
ADDR_WIDTH, 24, DRAM byte-address width
DATA_WIDTH, 8, element width (one memory beat)
TILE_WIDTH, 256, tile width in bits
TILE_ELEMS, TILE_WIDTH/DATA_WIDTH, elements per tile (32 at defaults)
TIMEOUT_CYCLES, 1024, mem_ready wait limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin operation; sampled only in IDLE
dram_addr  in  ADDR_WIDTH  DRAM base byte address
length  in  10  element count, 0..1023
buf_id  in  5  source buffer id
buf_read_en  out  1  one-cycle tile read request
buf_read_id  out  5  buffer id for read request
buf_read_data  in  DATA_WIDTH x TILE_ELEMS  returned tile
buf_read_done  in  1  tile valid, single-cycle strobe
mem_req  out  1  memory write request
mem_we  out  1  write enable, always equal to mem_req
mem_addr  out  ADDR_WIDTH  write byte address
mem_wdata  out  DATA_WIDTH  write byte
mem_ready  in  1  memory accepts beat
done  out  1  one-cycle completion pulse
error  out  1  timeout abort pulse

Behaviour:
- Reset: state IDLE; every output is 0, including buf_read_id and mem_addr. Counters are cleared. The tile register need not be cleared.
- Reset mid-operation: aborts immediately with no done pulse. A start after reset release behaves normally.
- States: IDLE, RD_REQ, RD_WAIT, WRITE, FINISH.
- IDLE:
  - On start, latch dram_addr, length and buf_id; clear the byte counter (10 bits) and element index.
  - If length==0, go to FINISH. Otherwise go to RD_REQ.
- RD_REQ: buf_read_en=1 for exactly one cycle with buf_read_id=latched buf_id, then go to RD_WAIT.
- Tile ordering: each buf_read_en pulse returns the next sequential tile; the buffer controller owns the read pointer.
- RD_WAIT:
  - On buf_read_done, register all TILE_ELEMS elements, set elem_idx=0 and go to WRITE.
  - There is no cycle limit on waiting for buf_read_done.
- WRITE:
  - mem_req=mem_we=1, mem_addr=base+byte_count (modulo 2^ADDR_WIDTH), mem_wdata=tile[elem_idx]. All are registered outputs.
  - Outputs hold stable until an edge where mem_req and mem_ready are both high (a handshake).
  - On handshake: byte_count++, elem_idx++.
    - If byte_count now equals length: deassert mem_req and go to FINISH.
    - Else if elem_idx wraps past TILE_ELEMS-1: deassert mem_req and go to RD_REQ.
    - Else present the next byte the following cycle. Back-to-back is allowed: 1 byte/cycle while mem_ready stays high.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Timing:
  - First buf_read_en occurs one cycle after the start edge.
  - done occurs one cycle after the final handshake edge, or one cycle after the start edge when length==0.
- Tile count: ceil(length/TILE_ELEMS). For a partial last tile, trailing elements are never written.
- start while not in IDLE is ignored. Inputs are not re-sampled mid-operation.
- buf_read_done outside RD_WAIT is ignored.
- mem_ready outside WRITE is ignored.

Optional Feature:
STORE_SER_TIMEOUT_EN.
- Defined: a cycle counter runs while in WRITE with mem_ready low and resets on each handshake.
  - When it reaches TIMEOUT_CYCLES, drop mem_req and pulse error for one cycle (no done pulse), then return to IDLE.
- Undefined: no counter exists, error is tied 0, and waits are unbounded.

Test Plan:
- length=5, dram_addr=0x000100, tile[i]=i+1, mem_ready=1 -> one buf_read_en with buf_read_id=buf_id; writes 0x100..0x104 with data 1..5 back-to-back; done one cycle after the 5th handshake.
- length=70, three tiles -> exactly 3 buf_read_en pulses; 70 writes to addresses base..base+69 with data matching tile order; mem_req low between tiles; single done.
- length=0 -> no buf_read_en, no mem_req; done high in the cycle following the start edge.
- mem_ready held low for 7 cycles on the 3rd byte -> mem_addr and mem_wdata stable throughout; no skipped or duplicated bytes; total handshakes equal length.
- dram_addr=0xFFFFFE, length=4 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- rst asserted during WRITE of byte 10 of 32 -> all outputs 0 asynchronously and no done; subsequent start with length=3 completes normally. With STORE_SER_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready stuck low -> error pulse after 16 cycles, no done, return to IDLE.
